// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the serial nibble adder.
// Holds the slice width, the FSM state encoding and the index/counter widths.
package adder_pkg;

   localparam int SLICE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int nslice(input int width);
      return width / SLICE_W;
   endfunction

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/serial_add_sequencer_slice.sv
// Four-bit ripple-carry slice built from four gate-level full adders.
// c3 is the carry into bit 3, used for signed overflow on the top slice.
module carry_slice4 (
   output logic [3:0] s,
   output logic       cout,
   output logic       c3,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin
);

   logic [4:0] c;
   logic [3:0] p;
   logic [3:0] g;

   assign c[0] = cin;

   for (genvar i = 0; i < 4; i++) begin : g_fa
      assign p[i]   = a[i] ^ b[i];
      assign g[i]   = a[i] & b[i];
      assign s[i]   = p[i] ^ c[i];
      assign c[i+1] = g[i] | (p[i] & c[i]);
   end

   assign cout = c[4];
   assign c3   = c[3];

endmodule

// File: rtl/serial_add_sequencer.sv
// Multi-cycle WIDTH-bit adder reusing one 4-bit slice, LSB nibble first,
// with a registered carry chain and SETTLE wait cycles per slice.
module serial_add_sequencer
   import adder_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int SETTLE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             over,
   output logic             busy,
   output logic [1:0]       dbg_state
);

   localparam int NSLICE = nslice(WIDTH);
   localparam int IDX_W  = cnt_width(NSLICE);
   localparam int CNT_W  = cnt_width(SETTLE + 1);
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NSLICE - 1);
   localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both 1; start_ready is high only in IDLE and res_valid only in DONE.

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     a_q, a_d;
   logic [WIDTH-1:0]     b_q, b_d;
   logic [WIDTH-1:0]     sum_q, sum_d;
   logic                 carry_q, carry_d;
   logic                 cout_q, cout_d;
   logic                 over_q, over_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   logic [SLICE_W-1:0]   slice_a;
   logic [SLICE_W-1:0]   slice_b;
   logic [SLICE_W-1:0]   slice_s;
   logic                 slice_cout;
   logic                 slice_c3;

   assign slice_a = a_q[int'(idx_q) * SLICE_W +: SLICE_W];
   assign slice_b = b_q[int'(idx_q) * SLICE_W +: SLICE_W];

   carry_slice4 u_slice (
      .s    (slice_s),
      .cout (slice_cout),
      .c3   (slice_c3),
      .a    (slice_a),
      .b    (slice_b),
      .cin  (carry_q)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      over_d  = over_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;

      case (state_q)
         IDLE: begin
            if (start_valid) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               sum_d   = '0;
               cout_d  = 1'b0;
               over_d  = 1'b0;
               idx_d   = '0;
               cnt_d   = SETTLE_CNT;
               state_d = ADD;
            end
         end
         ADD: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               sum_d[int'(idx_q) * SLICE_W +: SLICE_W] = slice_s;
               carry_d = slice_cout;
               if (idx_q == LAST_IDX) begin
                  cout_d  = slice_cout;
                  over_d  = slice_c3 ^ slice_cout;
                  state_d = DONE;
               end else begin
                  idx_d = idx_q + 1'b1;
                  cnt_d = SETTLE_CNT;
               end
            end
         end
         DONE: begin
            if (res_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         over_q  <= 1'b0;
         idx_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         over_q  <= over_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

   assign start_ready = (state_q == IDLE);
   assign res_valid   = (state_q == DONE);
   assign busy        = (state_q == ADD) || (state_q == DONE);
   assign sum         = sum_q;
   assign cout        = cout_q;
   assign over        = over_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed bench for serial_add_sequencer at WIDTH=16, SETTLE=1.
// Expected sums, flags and latencies are hand-computed constants.
module tb_serial_add_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_valid = 1'b0;
   logic        start_ready;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        cin = 1'b0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [15:0] sum;
   logic        cout;
   logic        over;
   logic        busy;
   logic [1:0]  dbg_state;

   int          vectors = 0;
   int          miscompares = 0;

   logic [15:0] got_sum;
   logic        got_cout;
   logic        got_over;
   int          got_lat;

   serial_add_sequencer #(.WIDTH(16), .SETTLE(1)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .a           (a),
      .b           (b),
      .cin         (cin),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .sum         (sum),
      .cout        (cout),
      .over        (over),
      .busy        (busy),
      .dbg_state   (dbg_state)
   );

   always #5 clk = ~clk;

   // Drive one op, scramble the inputs after accept, and wait for res_valid.
   task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic ci);
      @(negedge clk);
      a = av; b = bv; cin = ci; start_valid = 1'b1;
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      a = ~av; b = ~bv; cin = ~ci;
      got_lat = 0;
      while (res_valid !== 1'b1 && got_lat < 100) begin
         @(posedge clk);
         #1;
         got_lat++;
      end
      got_sum = sum; got_cout = cout; got_over = over;
   endtask

   task automatic release_result();
      @(negedge clk);
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      vectors++;
      if ({start_ready, res_valid, busy, sum, cout, over, dbg_state} !== {1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 2'd0}) begin
         miscompares++;
         $display("FAIL reset: got rdy=%b vld=%b busy=%b sum=%h cout=%b over=%b st=%0d, need rdy=1 vld=0 busy=0 sum=0000 cout=0 over=0 st=0",
                  start_ready, res_valid, busy, sum, cout, over, dbg_state);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_arith();
      logic [15:0] va [6];
      logic [15:0] vb [6];
      logic [15:0] vs [6];
      logic        vci[6];
      logic        vco[6];
      logic        vov[6];
      va = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h8000};
      vb = '{16'h0001, 16'h0001, 16'h0001, 16'h8000, 16'hFFFF, 16'hFFFF};
      vci = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      vs = '{16'h0001, 16'h0000, 16'h8000, 16'h0000, 16'hFFFF, 16'h7FFF};
      vco = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      vov = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 6; i++) begin
         run_op(va[i], vb[i], vci[i]);
         vectors++;
         if (got_lat !== 8) begin
            miscompares++;
            $display("FAIL arith[%0d] latency: got %0d cycles, need 8", i, got_lat);
         end
         vectors++;
         if ({got_sum, got_cout, got_over} !== {vs[i], vco[i], vov[i]}) begin
            miscompares++;
            $display("FAIL arith[%0d] %h+%h+%b: got sum=%h cout=%b over=%b, need sum=%h cout=%b over=%b",
                     i, va[i], vb[i], vci[i], got_sum, got_cout, got_over, vs[i], vco[i], vov[i]);
         end
         release_result();
         vectors++;
         if ({start_ready, res_valid, busy} !== 3'b100) begin
            miscompares++;
            $display("FAIL arith[%0d] after release: got rdy=%b vld=%b busy=%b, need 1 0 0", i, start_ready, res_valid, busy);
         end
      end
   endtask

   task automatic test_backpressure();
      run_op(16'h0F0F, 16'h0101, 1'b0);
      vectors++;
      if ({got_sum, got_cout, got_over} !== {16'h1010, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL bp result: got sum=%h cout=%b over=%b, need sum=1010 cout=0 over=0", got_sum, got_cout, got_over);
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (c == 1) begin
            a = 16'h1111; b = 16'h1111; cin = 1'b0; start_valid = 1'b1;
         end else begin
            start_valid = 1'b0;
         end
         @(posedge clk);
         #1;
         vectors++;
         if ({res_valid, start_ready, busy, sum, cout, over} !== {1'b1, 1'b0, 1'b1, 16'h1010, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL bp hold[%0d]: got vld=%b rdy=%b busy=%b sum=%h cout=%b over=%b, need 1 0 1 1010 0 0",
                     c, res_valid, start_ready, busy, sum, cout, over);
         end
      end
      start_valid = 1'b0;
      release_result();
      // The ignored start must not have queued an op: stay idle with no result.
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         vectors++;
         if ({start_ready, res_valid, busy} !== 3'b100) begin
            miscompares++;
            $display("FAIL bp idle[%0d]: got rdy=%b vld=%b busy=%b, need 1 0 0", c, start_ready, res_valid, busy);
         end
      end
   endtask

   task automatic test_reset_mid_op();
      @(negedge clk);
      a = 16'hFFFF; b = 16'hFFFF; cin = 1'b0; start_valid = 1'b1;
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      vectors++;
      if ({sum, busy, res_valid} !== {16'h00FE, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL mid-op partial: got sum=%h busy=%b vld=%b, need sum=00fe busy=1 vld=0", sum, busy, res_valid);
      end
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({start_ready, res_valid, busy, sum, cout, over} !== {1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL mid-op abort: got rdy=%b vld=%b busy=%b sum=%h cout=%b over=%b, need 1 0 0 0000 0 0",
                  start_ready, res_valid, busy, sum, cout, over);
      end
      @(negedge clk);
      rst_n = 1'b1;
      run_op(16'h1234, 16'h4321, 1'b1);
      vectors++;
      if ({got_sum, got_cout, got_over, got_lat} !== {16'h5556, 1'b0, 1'b0, 32'd8}) begin
         miscompares++;
         $display("FAIL post-reset op: got sum=%h cout=%b over=%b lat=%0d, need sum=5556 cout=0 over=0 lat=8",
                  got_sum, got_cout, got_over, got_lat);
      end
      release_result();
   endtask

   task automatic test_back_to_back();
      int t;
      int t_rv1;
      int t_acc2;
      int t_rv2;
      logic [15:0] s1;
      logic [15:0] s2;
      logic        c2;
      logic        o2;
      logic        prev_busy;
      t_rv1 = -1; t_acc2 = -1; t_rv2 = -1;
      s1 = '0; s2 = '0; c2 = 1'b0; o2 = 1'b0;
      @(negedge clk);
      res_ready = 1'b1;
      a = 16'h1111; b = 16'h2222; cin = 1'b0; start_valid = 1'b1;
      @(posedge clk);
      #1;
      a = 16'hABCD; b = 16'h1234; cin = 1'b0;
      t = 0;
      prev_busy = busy;
      while (t_rv2 < 0 && t < 60) begin
         @(posedge clk);
         #1;
         t++;
         if (res_valid === 1'b1 && t_rv1 < 0) begin
            t_rv1 = t; s1 = sum;
         end else if (res_valid === 1'b1 && t_acc2 >= 0) begin
            t_rv2 = t; s2 = sum; c2 = cout; o2 = over;
         end
         if (t_rv1 >= 0 && t_acc2 < 0 && prev_busy === 1'b0 && busy === 1'b1) begin
            t_acc2 = t;
            start_valid = 1'b0;
         end
         prev_busy = busy;
      end
      start_valid = 1'b0;
      res_ready = 1'b0;
      vectors++;
      if (t_rv1 !== 8 || s1 !== 16'h3333) begin
         miscompares++;
         $display("FAIL b2b first: got t=%0d sum=%h, need t=8 sum=3333", t_rv1, s1);
      end
      vectors++;
      if (t_acc2 - t_rv1 < 2 || t_acc2 !== 10) begin
         miscompares++;
         $display("FAIL b2b accept gap: got second accept at %0d (first result %0d), need 10", t_acc2, t_rv1);
      end
      vectors++;
      if (t_rv2 !== 18 || {s2, c2, o2} !== {16'hBE01, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL b2b second: got t=%0d sum=%h cout=%b over=%b, need t=18 sum=be01 cout=0 over=0", t_rv2, s2, c2, o2);
      end
      repeat (2) @(posedge clk);
   endtask

   initial begin
      test_reset();
      test_arith();
      test_backpressure();
      test_reset_mid_op();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
